jk_cmd_sequencer: RTL and testbench
===================================

Name: jk_cmd_sequencer

Overview:
Upstream stimulus stage for the JK-to-D flip-flop block. It accepts JK commands over a valid/ready handshake, each with a repeat count, and buffers them in a small FIFO. It then drives the J/K pins of the downstream flip-flop one command at a time, holding each pair for the requested number of cycles. When idle it drives J=K=0, which is the flip-flop's hold condition.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
RPT_W, 4, width of the repeat-count field; a command with count N holds for N+1 cycles.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present on cmd_jk/cmd_rpt.
cmd_ready  output  1  FIFO can accept a command; equals !full.
cmd_jk  input  2  command pair {J,K}; bit1=J, bit0=K.
cmd_rpt  input  RPT_W  extra hold cycles for this command.
J  output  1  registered J to the downstream flip-flop.
K  output  1  registered K to the downstream flip-flop.
busy  output  1  high while a command is being driven (state ISSUE).
done  output  1  one-cycle pulse when the last buffered command finishes and the block returns to IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - FIFO emptied.
  - State goes to IDLE.
  - J=0, K=0, busy=0, done=0, repeat counter=0.
  - cmd_ready=1 in the cycle after reset.
- Reset mid-operation aborts the current command and discards all buffered commands.
- Push: a command is written to the FIFO when cmd_valid && cmd_ready at a rising edge.
- cmd_ready is purely !full; there is no pass-through when full, even if a pop happens in the same cycle.
- Pop uses the occupancy count registered before the current edge.
  - A command pushed into an empty FIFO cannot be popped on the same edge.
- Simultaneous push and pop: the count is unchanged; pointers wrap modulo DEPTH.
- FSM, state IDLE:
  - J=K=0, busy=0.
  - If the FIFO is non-empty at an edge: pop, load J/K from the entry, load cnt=cmd_rpt, go to ISSUE.
- FSM, state ISSUE:
  - J/K held, busy=1.
  - If cnt!=0: cnt decrements.
  - If cnt==0 and the FIFO is non-empty: pop the next entry back-to-back with no gap cycle; stay in ISSUE.
  - If cnt==0 and the FIFO is empty: J=K=0, done=1 for one cycle, go to IDLE.
- Latency: a command accepted at edge t into an idle, empty block appears on J/K after edge t+1. It is held for cmd_rpt+1 cycles.
- done is never asserted between back-to-back commands.
- cmd_jk=2'b11 (toggle) is passed through unchanged; the sequencer does not interpret command values.
- cmd_rpt at its maximum value (2^RPT_W-1) holds for 2^RPT_W cycles; no overflow.
- Inputs are ignored while cmd_valid=0; a stalled producer (cmd_ready=0) must hold its data stable.

Optional Feature:
Macro JK_SEQ_STATS_EN.
- Defined:
  - Adds output cmd_count [15:0], counting commands completed, i.e. the ISSUE→pop or ISSUE→IDLE transition at cnt==0.
  - The counter wraps 0xFFFF→0x0000 and is cleared by rst.
  - Adds output ovf_seen (1 bit): sticky, set when cmd_valid=1 while cmd_ready=0; cleared by rst.
- Not defined:
  - Neither port exists; no counter or flag logic is present.
  - Core behaviour is identical.

Test Plan:
1. Reset: assert rst for 2 cycles mid-ISSUE with 3 entries buffered → next cycle J=0, K=0, busy=0, done=0, cmd_ready=1, FIFO empty; no further commands are issued.
2. Single command: push {J,K}=2'b10, cmd_rpt=2 at edge t → J=1, K=0 after edges t+1..t+3 (3 cycles); J=K=0 and done=1 after edge t+4; done=0 after edge t+5.
3. Back-to-back: push 2'b01/rpt 0, 2'b10/rpt 1, 2'b11/rpt 0 on consecutive cycles → J/K sequence 01, 10, 10, 11 with no idle gap; done pulses exactly once, after the 11 cycle.
4. Full FIFO (DEPTH=4): hold a 2'b00/rpt 15 command in ISSUE and push 4 more → cmd_ready=0 after the 4th push. A 5th command held with cmd_valid=1 is accepted only on the edge after the first pop. All 6 commands are issued in order.
5. Max repeat: cmd_rpt=15 (RPT_W=4) → J/K held for exactly 16 cycles, then IDLE and a done pulse.
6. With JK_SEQ_STATS_EN defined: run scenario 3 → cmd_count=3. Then run scenario 4 → ovf_seen=1 and remains 1 until rst.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// JK command sequencer: buffers {J,K,repeat} commands in a small FIFO and drives J/K for repeat+1 cycles each.
// Defining JK_SEQ_STATS_EN adds the cmd_count and ovf_seen statistics outputs.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_jk,
  input  logic [RPT_W-1:0] cmd_rpt,
  output logic             J,
  output logic             K,
  output logic             busy,
`ifdef JK_SEQ_STATS_EN
  output logic [15:0]      cmd_count,
  output logic             ovf_seen,
`endif
  output logic             done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = RPT_W + 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_ZERO = '0;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] occ;
  logic [RPT_W-1:0] cnt_q;
  logic [ENT_W-1:0] head;
  logic             full, empty, push, pop, dec, clr, done_d;

  assign full      = (occ == FULL_CNT);
  assign empty     = (occ == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr];
  assign busy      = (state_q == ISSUE);

  // FIFO storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_jk, cmd_rpt};
  end

  // FIFO control: pop is decided from the occupancy held before this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + CNT_ONE;
        2'b01:   occ <= occ - CNT_ONE;
        default: occ <= occ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    dec     = 1'b0;
    clr     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q != RPT_ZERO) begin
          dec = 1'b1;
        end else if (!empty) begin
          pop = 1'b1;
        end else begin
          clr     = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: J/K and the hold counter load together from the FIFO head
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      J       <= 1'b0;
      K       <= 1'b0;
      cnt_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (pop) begin
        J     <= head[ENT_W-1];
        K     <= head[ENT_W-2];
        cnt_q <= head[RPT_W-1:0];
      end else if (dec) begin
        cnt_q <= cnt_q - RPT_ONE;
      end else if (clr) begin
        J <= 1'b0;
        K <= 1'b0;
      end
    end
  end

`ifdef JK_SEQ_STATS_EN
  // A command completes on the ISSUE cycle whose hold counter has reached zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_count <= '0;
      ovf_seen  <= 1'b0;
    end else begin
      if (busy && (cnt_q == RPT_ZERO)) cmd_count <= cmd_count + 16'd1;
      if (cmd_valid && !cmd_ready)     ovf_seen  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: vector table, directed corner sequences and randomized traffic
// against a timeline model (each command's start/end edge computed from its push edge and repeat count).
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int RPT_W = 4;

  logic             clk = 1'b0;
  logic             rst, cmd_valid, cmd_ready, J, K, busy, done;
  logic [1:0]       cmd_jk;
  logic [RPT_W-1:0] cmd_rpt;
`ifdef JK_SEQ_STATS_EN
  logic [15:0]      cmd_count;
  logic             ovf_seen;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_jk    (cmd_jk),
    .cmd_rpt   (cmd_rpt),
    .J         (J),
    .K         (K),
    .busy      (busy),
`ifdef JK_SEQ_STATS_EN
    .cmd_count (cmd_count),
    .ovf_seen  (ovf_seen),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  // p = push edge, s = first edge it is driven, e = edge at which it stops being driven
  typedef struct { int p; int s; int e; logic [1:0] jk; } mcmd_t;
  mcmd_t mq[$];

  // exp = {J, K, busy, done, cmd_ready} after the edge the row is applied on
  typedef struct { logic v; logic [1:0] jk; logic [3:0] rpt; logic [4:0] exp; } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int occ_after(int k);
    int n = 0;
    foreach (mq[i]) begin
      if (mq[i].p <= k) n++;
      if (mq[i].s <= k) n--;
    end
    return n;
  endfunction

  function automatic logic [4:0] model_out(int k);
    logic j = 1'b0, kk = 1'b0, b = 1'b0;
    bit ended = 0, started = 0;
    foreach (mq[i]) begin
      if (mq[i].s <= k && k < mq[i].e) begin
        j  = mq[i].jk[1];
        kk = mq[i].jk[0];
        b  = 1'b1;
      end
      if (mq[i].e == k) ended = 1;
      if (mq[i].s == k) started = 1;
    end
    return {j, kk, b, (ended && !started), (occ_after(k) < DEPTH)};
  endfunction

  task automatic step(input logic v, input logic [1:0] jk, input logic [RPT_W-1:0] rpt, output bit acc);
    int s, ep;
    cmd_valid = v;
    cmd_jk    = jk;
    cmd_rpt   = rpt;
    acc = v && (occ_after(cyc) < DEPTH);
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      ep = (mq.size() > 0) ? mq[mq.size()-1].e : 0;
      s  = (cyc + 1 > ep) ? cyc + 1 : ep;
      mq.push_back('{cyc, s, s + int'(rpt) + 1, jk});
    end
    chk("model", int'({J, K, busy, done, cmd_ready}), int'(model_out(cyc)));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    mq.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit pend;
    int hold;
    int rdy_cyc;
    int t0;
    logic [1:0] rj;
    logic [3:0] rr;

    rst = 1'b1; cmd_valid = 1'b0; cmd_jk = 2'b00; cmd_rpt = '0;

    // single command 10/rpt2, then back-to-back 01/0, 10/1, 11/0
    vt[0]  = '{1'b1, 2'b10, 4'd2, 5'b00001};
    vt[1]  = '{1'b0, 2'b00, 4'd0, 5'b10101};
    vt[2]  = '{1'b0, 2'b00, 4'd0, 5'b10101};
    vt[3]  = '{1'b0, 2'b00, 4'd0, 5'b10101};
    vt[4]  = '{1'b0, 2'b00, 4'd0, 5'b00011};
    vt[5]  = '{1'b0, 2'b00, 4'd0, 5'b00001};
    vt[6]  = '{1'b1, 2'b01, 4'd0, 5'b00001};
    vt[7]  = '{1'b1, 2'b10, 4'd1, 5'b01101};
    vt[8]  = '{1'b1, 2'b11, 4'd0, 5'b10101};
    vt[9]  = '{1'b0, 2'b00, 4'd0, 5'b10101};
    vt[10] = '{1'b0, 2'b00, 4'd0, 5'b11101};
    vt[11] = '{1'b0, 2'b00, 4'd0, 5'b00011};
    vt[12] = '{1'b0, 2'b00, 4'd0, 5'b00001};

    do_reset();
    chk("reset_state", int'({J, K, busy, done, cmd_ready}), 32'h01);
`ifdef JK_SEQ_STATS_EN
    chk("reset_count", int'(cmd_count), 0);
    chk("reset_ovf", int'(ovf_seen), 0);
`endif

    for (int i = 0; i < 13; i++) begin
      step(vt[i].v, vt[i].jk, vt[i].rpt, acc);
      chk($sformatf("vec%0d", i), int'({J, K, busy, done, cmd_ready}), int'(vt[i].exp));
`ifdef JK_SEQ_STATS_EN
      if (i == 5) chk("count_single", int'(cmd_count), 1);
`endif
    end
`ifdef JK_SEQ_STATS_EN
    chk("count_b2b", int'(cmd_count), 4);
`endif

    // full FIFO: long command in ISSUE, four more fill the FIFO, fifth waits for the first pop
    t0 = cyc + 1;
    step(1'b1, 2'b00, 4'd15, acc);
    step(1'b1, 2'b01, 4'd1, acc);
    step(1'b1, 2'b10, 4'd0, acc);
    step(1'b1, 2'b11, 4'd2, acc);
    step(1'b1, 2'b01, 4'd0, acc);
    chk("full_ready_low", int'(cmd_ready), 0);
    rdy_cyc = -1;
    for (int n = 0; n < 40 && rdy_cyc < 0; n++) begin
      step(1'b1, 2'b10, 4'd1, acc);
      if (cmd_ready) rdy_cyc = cyc;
    end
    chk("ready_after_first_pop", rdy_cyc, t0 + 17);
    step(1'b1, 2'b10, 4'd1, acc);
    for (int n = 0; n < 20; n++) step(1'b0, 2'b11, 4'd7, acc);
`ifdef JK_SEQ_STATS_EN
    chk("ovf_set", int'(ovf_seen), 1);
    for (int n = 0; n < 5; n++) step(1'b0, 2'b00, 4'd0, acc);
    chk("ovf_sticky", int'(ovf_seen), 1);
`endif

    // reset during ISSUE with three commands buffered
    step(1'b1, 2'b11, 4'd15, acc);
    step(1'b1, 2'b01, 4'd3, acc);
    step(1'b1, 2'b10, 4'd3, acc);
    step(1'b1, 2'b11, 4'd3, acc);
    step(1'b0, 2'b00, 4'd0, acc);
    step(1'b0, 2'b00, 4'd0, acc);
    chk("busy_before_reset", int'({J, K, busy}), 32'h7);
    do_reset();
    chk("reset_mid_issue", int'({J, K, busy, done, cmd_ready}), 32'h01);
`ifdef JK_SEQ_STATS_EN
    chk("reset_clears_count", int'(cmd_count), 0);
    chk("reset_clears_ovf", int'(ovf_seen), 0);
`endif
    for (int n = 0; n < 25; n++) step(1'b0, 2'b11, 4'd5, acc);
    chk("idle_after_reset", int'({J, K, busy, done}), 0);

    // maximum repeat count holds for 2^RPT_W cycles
    step(1'b1, 2'b10, 4'd15, acc);
    hold = 0;
    for (int n = 0; n < 40; n++) begin
      step(1'b0, 2'b00, 4'd0, acc);
      if (J && !K) hold++;
      else break;
    end
    chk("max_rpt_hold", hold, 16);
    chk("max_rpt_done", int'({J, K, busy, done}), 32'h1);
    step(1'b0, 2'b00, 4'd0, acc);
    chk("done_one_cycle", int'(done), 0);

    // randomized traffic; a refused command is held stable until accepted
    pend = 0;
    rj = 2'b00;
    rr = 4'd0;
    for (int n = 0; n < 1500; n++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        rj   = 2'($urandom_range(0, 3));
        rr   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        pend = 1;
      end
      if (pend) begin
        step(1'b1, rj, rr, acc);
        if (acc) pend = 0;
      end else begin
        step(1'b0, 2'($urandom), 4'($urandom), acc);
      end
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        pend = 0;
        chk("rand_reset", int'({J, K, busy, done, cmd_ready}), 32'h01);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
